spi_frame_loader: RTL and testbench

Host-side master that programs and launches the tiny processor over its serial slave interface. Accepts write/run commands via valid/ready. Write commands are serialized into 12-bit frames (4-bit address, 8-bit data) on mosi, framed by csi_n or csd_n. Run commands drive the processor enable until the processor reports done. Sits directly upstream of the processor's shift buffer and control FSM.

---
 rtl/spi_frame_loader.sv | 161 ++++++++++++++++
 tb/tb_spi_frame_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_loader.sv
// Host-side SPI master: serialises cache write commands into 12-bit frames and runs the processor.
// Optional run watchdog enabled by defining RUN_TIMEOUT_EN (timeout counter, sticky timeout flag).
module spi_frame_loader #(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [3:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       csi_n,
    output logic       csd_n,
    output logic       mosi,
    output logic       proc_en,
    input  logic       done_in,
    output logic       run_done,
    output logic       timeout
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SHIFT     = 3'd1;
    localparam logic [2:0] GAP       = 3'd2;
    localparam logic [2:0] RUN_START = 3'd3;
    localparam logic [2:0] RUN_WAIT  = 3'd4;

    // The IDLE cycle before the next accept also keeps both CS high, so GAP
    // itself lasts GAP_CYCLES-1 cycles and is skipped entirely when GAP_CYCLES=1.
    localparam int         GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 1 ? GAP_CYCLES - 2 : 0);
    localparam logic [2:0] GAP_EXIT = (GAP_CYCLES > 1) ? GAP : IDLE;

    logic [2:0]    state;
    logic [3:0]    bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic [10:0]   shift_q;
    logic          csi_q;
    logic          csd_q;
    logic          mosi_q;
    logic          run_q;
    logic          started_q;
    logic          run_done_q;
    logic          accept;
    logic          in_run;
    logic          run_abort;

    assign accept    = cmd_valid & cmd_ready;
    assign in_run    = (state == RUN_START) || (state == RUN_WAIT);
    assign cmd_ready = (state == IDLE);
    assign csi_n     = csi_q;
    assign csd_n     = csd_q;
    assign mosi      = mosi_q;
    assign run_done  = run_done_q;
    // Combinational from done_in so the processor never sees enable on the cycle done rises.
    assign proc_en   = run_q & ~(started_q & done_in);

`ifdef RUN_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt;
    logic          timeout_q;

    // Normal completion wins if done arrives on the same cycle the limit is reached.
    assign run_abort = in_run && (to_cnt == TO_LAST) && !((state == RUN_WAIT) && done_in);
    assign timeout   = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (accept && (cmd_type == 2'b10))
                to_cnt <= '0;
            else if (in_run)
                to_cnt <= to_cnt + 1'b1;
            if (run_abort)
                timeout_q <= 1'b1;
        end
    end
`else
    assign run_abort = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (accept)
            shift_q <= {cmd_data, cmd_addr[3:1]};
        else if (state == SHIFT)
            shift_q <= shift_q >> 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            gap_cnt    <= '0;
            csi_q      <= 1'b1;
            csd_q      <= 1'b1;
            mosi_q     <= 1'b0;
            run_q      <= 1'b0;
            started_q  <= 1'b0;
            run_done_q <= 1'b0;
        end else begin
            run_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (cmd_type)
                            2'b00, 2'b01: begin
                                state   <= SHIFT;
                                bit_cnt <= 4'd0;
                                csi_q   <= cmd_type[0];
                                csd_q   <= ~cmd_type[0];
                                mosi_q  <= cmd_addr[0];
                            end
                            2'b10: begin
                                state     <= RUN_START;
                                run_q     <= 1'b1;
                                started_q <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                SHIFT: begin
                    if (bit_cnt == 4'd11) begin
                        state   <= GAP_EXIT;
                        gap_cnt <= '0;
                        csi_q   <= 1'b1;
                        csd_q   <= 1'b1;
                        mosi_q  <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        mosi_q  <= shift_q[0];
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST)
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                RUN_START, RUN_WAIT: begin
                    if (run_abort || ((state == RUN_WAIT) && done_in)) begin
                        state      <= GAP_EXIT;
                        gap_cnt    <= '0;
                        run_q      <= 1'b0;
                        started_q  <= 1'b0;
                        run_done_q <= 1'b1;
                    end else if ((state == RUN_START) && !done_in) begin
                        started_q <= 1'b1;
                        state     <= RUN_WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed bench for spi_frame_loader with a serial slave model and a processor model.
// Timeout scenario expectations switch on RUN_TIMEOUT_EN.
module tb_spi_frame_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       csi_n;
    logic       csd_n;
    logic       mosi;
    logic       proc_en;
    logic       done_in;
    logic       run_done;
    logic       timeout;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    spi_frame_loader #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .csi_n(csi_n), .csd_n(csd_n), .mosi(mosi), .proc_en(proc_en),
        .done_in(done_in), .run_done(run_done), .timeout(timeout)
    );

    // Serial slave: shifts mosi LSB-first while a CS is low, commits a full frame on CS rise.
    logic [11:0] sl_sr = 12'h0;
    int          sl_n = 0;
    logic        sl_sel = 1'b0;
    logic [7:0]  icache [16];
    logic [7:0]  dcache [16];

    always @(posedge clk) begin
        if (!csi_n || !csd_n) begin
            sl_sr  <= {mosi, sl_sr[11:1]};
            sl_n   <= sl_n + 1;
            sl_sel <= !csd_n;
        end else begin
            if (sl_n == 12) begin
                if (sl_sel) dcache[sl_sr[3:0]] <= sl_sr[11:4];
                else        icache[sl_sr[3:0]] <= sl_sr[11:4];
            end
            sl_n <= 0;
        end
    end

    // Processor: enters EXEC when enabled while idle, done low for 20 cycles.
    logic model_en = 1'b0;
    logic forced_done = 1'b1;
    logic model_done = 1'b1;
    logic model_busy = 1'b0;
    int   model_cnt = 0;
    int   exec_entries = 0;

    assign done_in = model_en ? model_done : forced_done;

    always @(posedge clk) begin
        if (!model_en) begin
            model_done <= 1'b1;
            model_busy <= 1'b0;
        end else if (!model_busy) begin
            if (proc_en) begin
                model_busy   <= 1'b1;
                model_done   <= 1'b0;
                model_cnt    <= 0;
                exec_entries <= exec_entries + 1;
            end
        end else if (model_cnt == 19) begin
            model_busy <= 1'b0;
            model_done <= 1'b1;
        end else begin
            model_cnt <= model_cnt + 1;
        end
    end

    // Waits (bounded) for cmd_ready, presents one command, returns at the cycle after acceptance.
    task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d);
        int w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 60) begin
            @(negedge clk);
            w++;
        end
        total_cnt++;
        if (!cmd_ready) $display("FAIL issue_ready got=%b exp=1", cmd_ready);
        else pass_cnt++;
        cmd_type  = t;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_type = 2'b00; cmd_addr = 4'h0; cmd_data = 8'h00;
        repeat (3) @(negedge clk);
        total_cnt++; if (csi_n !== 1'b1) $display("FAIL rst_csi_n got=%b exp=1", csi_n); else pass_cnt++;
        total_cnt++; if (csd_n !== 1'b1) $display("FAIL rst_csd_n got=%b exp=1", csd_n); else pass_cnt++;
        total_cnt++; if (mosi !== 1'b0) $display("FAIL rst_mosi got=%b exp=0", mosi); else pass_cnt++;
        total_cnt++; if (proc_en !== 1'b0) $display("FAIL rst_proc_en got=%b exp=0", proc_en); else pass_cnt++;
        total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", cmd_ready); else pass_cnt++;
        total_cnt++; if (run_done !== 1'b0) $display("FAIL rst_run_done got=%b exp=0", run_done); else pass_cnt++;
        total_cnt++; if (timeout !== 1'b0) $display("FAIL rst_timeout got=%b exp=0", timeout); else pass_cnt++;
        rst = 1'b0;
        issue(2'b00, 4'h5, 8'h3C);
        repeat (4) @(negedge clk);
        total_cnt++; if (csi_n !== 1'b0) $display("FAIL midframe_csi_n got=%b exp=0", csi_n); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({csi_n, csd_n, mosi, proc_en, cmd_ready} !== 5'b11001)
            $display("FAIL abort_outputs got=%b exp=11001", {csi_n, csd_n, mosi, proc_en, cmd_ready});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({csi_n, csd_n, mosi, cmd_ready} !== 4'b1101)
            $display("FAIL post_rst_idle got=%b exp=1101", {csi_n, csd_n, mosi, cmd_ready});
        else pass_cnt++;
    endtask

    task automatic test_write_icache();
        logic [11:0] exp_frame = 12'hA53;
        logic [11:0] got = 12'h000;
        int bad = 0;
        int lo_d = 0;
        issue(2'b00, 4'h3, 8'hA5);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            if (!csd_n) lo_d++;
            if (i < 12) begin
                got[i] = mosi;
                if (csi_n !== 1'b0) bad++;
            end else if (csi_n !== 1'b1 || mosi !== 1'b0) begin
                bad++;
            end
        end
        total_cnt++; if (got !== exp_frame) $display("FAIL wr_mosi_bits got=%h exp=%h", got, exp_frame); else pass_cnt++;
        total_cnt++; if (bad != 0) $display("FAIL wr_cs_window got=%0d bad cycles exp=0", bad); else pass_cnt++;
        total_cnt++; if (lo_d != 0) $display("FAIL wr_csd_quiet got=%0d low cycles exp=0", lo_d); else pass_cnt++;
        total_cnt++; if (icache[3] !== 8'hA5) $display("FAIL wr_icache3 got=%h exp=a5", icache[3]); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int  k = 0, acc0 = -1, acc1 = -1, w = 0;
        int  lo_i = 0, lo_d = 0, run_hi = 0, min_hi = 1000;
        bit  pend = 0, seen_lo = 0, prev_lo = 0;
        @(negedge clk);
        while (!cmd_ready && w < 60) begin
            @(negedge clk);
            w++;
        end
        cmd_type = 2'b01; cmd_addr = 4'h0; cmd_data = 8'h7F; cmd_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            if (pend) begin
                pend = 0;
                if (k == 1) begin cmd_addr = 4'hF; cmd_data = 8'h80; end
                else cmd_valid = 1'b0;
            end
            if (!csi_n) lo_i++;
            if (!csd_n) begin
                lo_d++;
                if (seen_lo && !prev_lo && run_hi < min_hi) min_hi = run_hi;
                seen_lo = 1; prev_lo = 1; run_hi = 0;
            end else begin
                run_hi++; prev_lo = 0;
            end
            if (cmd_valid && cmd_ready) begin
                if (k == 0) acc0 = c; else acc1 = c;
                k++; pend = 1;
            end
        end
        total_cnt++; if (acc0 != 0) $display("FAIL b2b_first_accept got=%0d exp=0", acc0); else pass_cnt++;
        total_cnt++; if (acc1 - acc0 != 14) $display("FAIL b2b_accept_spacing got=%0d exp=14", acc1 - acc0); else pass_cnt++;
        total_cnt++; if (lo_d != 24) $display("FAIL b2b_csd_low got=%0d exp=24", lo_d); else pass_cnt++;
        total_cnt++; if (lo_i != 0) $display("FAIL b2b_csi_quiet got=%0d exp=0", lo_i); else pass_cnt++;
        total_cnt++; if (min_hi < 2 || min_hi > 10) $display("FAIL b2b_gap got=%0d exp>=2", min_hi); else pass_cnt++;
        total_cnt++; if (dcache[0] !== 8'h7F) $display("FAIL b2b_dcache0 got=%h exp=7f", dcache[0]); else pass_cnt++;
        total_cnt++; if (dcache[15] !== 8'h80) $display("FAIL b2b_dcache15 got=%h exp=80", dcache[15]); else pass_cnt++;
    endtask

    task automatic test_run();
        int  e0, rise_i = -1, rd_i = -1, rd_cnt = 0, ready_i = -1, viol = 0;
        bit  started = 0, saw_en = 0, prev_done = 1;
        model_en = 1'b1;
        e0 = exec_entries;
        issue(2'b10, 4'h0, 8'h00);
        for (int i = 0; i < 60; i++) begin
            if (i > 0) @(negedge clk);
            if (proc_en) saw_en = 1;
            if (!done_in) started = 1;
            if (started && done_in && !prev_done && rise_i < 0) rise_i = i;
            if (started && done_in && proc_en) viol++;
            if (run_done) begin rd_cnt++; rd_i = i; end
            if (rd_i >= 0 && i > rd_i && cmd_ready && ready_i < 0) ready_i = i;
            prev_done = done_in;
        end
        model_en = 1'b0;
        total_cnt++; if (!saw_en) $display("FAIL run_en_seen got=0 exp=1"); else pass_cnt++;
        total_cnt++; if (rise_i < 0) $display("FAIL run_done_in_rise got=none exp=rise"); else pass_cnt++;
        total_cnt++; if (viol != 0) $display("FAIL run_en_with_done got=%0d cycles exp=0", viol); else pass_cnt++;
        total_cnt++; if (rd_cnt != 1) $display("FAIL run_done_pulses got=%0d exp=1", rd_cnt); else pass_cnt++;
        total_cnt++; if (rd_i != rise_i + 1) $display("FAIL run_done_timing got=%0d exp=%0d", rd_i, rise_i + 1); else pass_cnt++;
        total_cnt++; if (exec_entries - e0 != 1) $display("FAIL run_exec_entries got=%0d exp=1", exec_entries - e0); else pass_cnt++;
        total_cnt++; if (ready_i != rd_i + 1) $display("FAIL run_ready_return got=%0d exp=%0d", ready_i, rd_i + 1); else pass_cnt++;
    endtask

    task automatic test_reserved();
        int bad = 0;
        issue(2'b11, 4'h7, 8'hFF);
        total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL rsv_ready got=%b exp=1", cmd_ready); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (!csi_n || !csd_n || proc_en) bad++;
        end
        total_cnt++; if (bad != 0) $display("FAIL rsv_quiet got=%0d active cycles exp=0", bad); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int en_cnt = 0, last_en = -1, to_i = -1, rd_cnt = 0, rd_i = -1;
        forced_done = 1'b1;
        issue(2'b10, 4'h0, 8'h00);
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            if (proc_en) begin en_cnt++; last_en = i; end
            if (run_done) begin rd_cnt++; rd_i = i; end
            if (timeout && to_i < 0) to_i = i;
        end
`ifdef RUN_TIMEOUT_EN
        total_cnt++; if (en_cnt != 15) $display("FAIL to_en_cycles got=%0d exp=15", en_cnt); else pass_cnt++;
        total_cnt++; if (last_en != 14) $display("FAIL to_en_last got=%0d exp=14", last_en); else pass_cnt++;
        total_cnt++; if (to_i != 15) $display("FAIL to_flag_cycle got=%0d exp=15", to_i); else pass_cnt++;
        total_cnt++; if (rd_cnt != 1 || rd_i != 15) $display("FAIL to_run_done got=%0d@%0d exp=1@15", rd_cnt, rd_i); else pass_cnt++;
        issue(2'b00, 4'h1, 8'h11);
        repeat (14) @(negedge clk);
        total_cnt++; if (timeout !== 1'b1) $display("FAIL to_sticky got=%b exp=1", timeout); else pass_cnt++;
        total_cnt++; if (icache[1] !== 8'h11) $display("FAIL to_write_after got=%h exp=11", icache[1]); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++; if (timeout !== 1'b0) $display("FAIL to_clear_rst got=%b exp=0", timeout); else pass_cnt++;
`else
        total_cnt++; if (en_cnt != 40) $display("FAIL to_waits got=%0d en cycles exp=40", en_cnt); else pass_cnt++;
        total_cnt++; if (rd_cnt != 0) $display("FAIL to_no_run_done got=%0d exp=0", rd_cnt); else pass_cnt++;
        total_cnt++; if (to_i != -1) $display("FAIL to_tied_low got=%0d exp=-1", to_i); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if (proc_en !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL to_abort_rst got=%b%b exp=01", proc_en, cmd_ready);
        else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_write_icache();
        test_back_to_back();
        test_run();
        test_reserved();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
